// File: rtl/spm_boot_ctrl_if.sv
// rtl/spm_boot_ctrl_if.sv - loader stream and controller-side SRAM port of the boot sequencer
interface spm_boot_ctrl_if #(
    parameter int word_size = 8,
    parameter int addr_size = 8
);
    logic                 ld_valid;
    logic                 ld_ready;
    logic [addr_size-1:0] ld_addr;
    logic [word_size-1:0] ld_data;
    logic                 ld_last;
    logic                 mem_sel;
    logic                 mem_we;
    logic [addr_size-1:0] mem_addr;
    logic [word_size-1:0] mem_din;

    // host side: produces the image stream, observes the SRAM port
    modport master (
        output ld_valid, ld_addr, ld_data, ld_last,
        input  ld_ready, mem_sel, mem_we, mem_addr, mem_din
    );

    // controller side
    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last,
        output ld_ready, mem_sel, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/spm_boot_ctrl.sv
// rtl/spm_boot_ctrl.sv - boot/run sequencer: clear SRAM, load image, release core, watch HALT/timeout
module spm_boot_ctrl #(
    parameter int word_size = 8,
    parameter int addr_size = 8,
    parameter int cyc_w     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [cyc_w-1:0] run_limit_i,
    input  logic             core_halt_i,
    spm_boot_ctrl_if.slave   bus,
    output logic             core_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [cyc_w-1:0] cycle_count_o,
    output logic [2:0]       state_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_HALTED  = 3'd5;
    localparam logic [2:0] S_TIMEOUT = 3'd6;

    localparam logic [addr_size-1:0] addr_one = 1;
    localparam logic [cyc_w-1:0]     cnt_one  = 1;

    logic [2:0]           state_q, state_d;
    logic [addr_size-1:0] clr_addr_q, clr_addr_d;
    logic [cyc_w-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 timeout_q, timeout_d;
    logic                 done_q, done_d;
    logic                 core_rst_n_q, mem_sel_q, busy_q, ld_ready_q;

    // next-state and counter logic; start is only honoured from the resting states
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + cnt_one;
        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (start_i) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = '0;
                    cnt_d      = '0;
                    timeout_d  = 1'b0;
                end
            end
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + addr_one;
                if (&clr_addr_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (bus.ld_valid && bus.ld_last) state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_RUN;
            S_RUN: begin
                cnt_d = cnt_inc;
                if (core_halt_i) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end else if ((run_limit_i != '0) && (cnt_inc == run_limit_i)) begin
                    state_d   = S_TIMEOUT;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; status outputs are registered from the next state so they never glitch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            clr_addr_q   <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
            mem_sel_q    <= 1'b1;
            busy_q       <= 1'b0;
            ld_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            core_rst_n_q <= (state_d == S_RUN) || (state_d == S_HALTED);
            mem_sel_q    <= !((state_d == S_RELEASE) || (state_d == S_RUN) || (state_d == S_HALTED));
            busy_q       <= (state_d == S_CLEAR) || (state_d == S_LOAD) ||
                            (state_d == S_RELEASE) || (state_d == S_RUN);
            ld_ready_q   <= (state_d == S_LOAD);
        end
    end

    // SRAM write port: zero-fill while clearing, pass the loader through while loading
    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = {word_size{1'b0}};
        if (state_q == S_CLEAR) begin
            bus.mem_we   = 1'b1;
            bus.mem_addr = clr_addr_q;
        end else if (state_q == S_LOAD) begin
            bus.mem_we   = bus.ld_valid;
            bus.mem_addr = bus.ld_addr;
            bus.mem_din  = bus.ld_data;
        end
    end

    assign bus.ld_ready  = ld_ready_q;
    assign bus.mem_sel   = mem_sel_q;
    assign core_rst_n_o  = core_rst_n_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign cycle_count_o = cnt_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_spm_boot_ctrl.sv
// tb/tb_spm_boot_ctrl.sv - directed bench with SRAM-write scoreboard for spm_boot_ctrl
module tb_spm_boot_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] run_limit = '0;
    logic        core_halt = 1'b0;
    logic        core_rst_n, busy, done, timeout;
    logic [15:0] cycle_count;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] img[$];

    spm_boot_ctrl_if #(.word_size(8), .addr_size(8)) bus ();

    spm_boot_ctrl #(.word_size(8), .addr_size(8), .cyc_w(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .run_limit_i(run_limit),
        .core_halt_i(core_halt), .bus(bus), .core_rst_n_o(core_rst_n), .busy_o(busy),
        .done_o(done), .timeout_o(timeout), .cycle_count_o(cycle_count), .state_o(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock cycle: sample the write port mid-cycle against the scoreboard, then step past the edge
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        if (bus.mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {31'b0, bus.mem_we}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {24'b0, bus.mem_addr}, {24'b0, e[15:8]});
                check("wr_data", {24'b0, bus.mem_din}, {24'b0, e[7:0]});
                check("wr_sel", {31'b0, bus.mem_sel}, 32'd1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_state", {29'b0, state}, 32'd0);
        check("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
        check("rst_mem_sel", {31'b0, bus.mem_sel}, 32'd1);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {24'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_din", {24'b0, bus.mem_din}, 32'd0);
        check("rst_ld_ready", {31'b0, bus.ld_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        check("rst_cycle_count", {16'b0, cycle_count}, 32'd0);
    endtask

    // pulse start, expect 256 zero writes in ascending order, then LOAD with ld_ready
    task automatic do_clear();
        for (int a = 0; a < 256; a++) exp_q.push_back({a[7:0], 8'h00});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clr_enter", {29'b0, state}, 32'd1);
        check("clr_timeout_cleared", {31'b0, timeout}, 32'd0);
        check("clr_count_cleared", {16'b0, cycle_count}, 32'd0);
        repeat (255) tick();
        check("clr_last_state", {29'b0, state}, 32'd1);
        check("clr_last_ready", {31'b0, bus.ld_ready}, 32'd0);
        tick();
        check("clr_done_state", {29'b0, state}, 32'd2);
        check("clr_ld_ready", {31'b0, bus.ld_ready}, 32'd1);
        check("clr_all_written", exp_q.size(), 32'd0);
    endtask

    task automatic load_word(input logic [7:0] a, input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        bus.ld_last  = last;
        exp_q.push_back({a, d});
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    // after the ld_last handshake: one RELEASE cycle, then RUN with the core out of reset
    task automatic check_release_to_run();
        check("rel_state", {29'b0, state}, 32'd3);
        check("rel_core_rst_n", {31'b0, core_rst_n}, 32'd0);
        check("rel_mem_sel", {31'b0, bus.mem_sel}, 32'd0);
        check("rel_ld_ready", {31'b0, bus.ld_ready}, 32'd0);
        tick();
        check("run_state", {29'b0, state}, 32'd4);
        check("run_core_rst_n", {31'b0, core_rst_n}, 32'd1);
        check("run_busy", {31'b0, busy}, 32'd1);
    endtask

    initial begin
        int k;
        int idx;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;

        tick();
        tick();
        check_reset_values();
        rst = 1'b0;
        tick();

        // ld_valid in IDLE must not write
        bus.ld_valid = 1'b1; bus.ld_addr = 8'h05; bus.ld_data = 8'h77;
        #1;
        check("idle_no_we", {31'b0, bus.mem_we}, 32'd0);
        tick();
        bus.ld_valid = 1'b0;
        check("idle_stays", {29'b0, state}, 32'd0);

        // clear, five transfers, ignored start in LOAD, then reset mid-LOAD
        do_clear();
        for (int i = 0; i < 5; i++) load_word(8'(i * 7), 8'(8'hA0 + i), 1'b0);
        check("load_5_state", {29'b0, state}, 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_start_ignored", {29'b0, state}, 32'd2);
        rst = 1'b1;
        tick();
        tick();
        check_reset_values();
        rst = 1'b0;

        // re-run clear, then the image with gaps on every third cycle
        do_clear();
        for (int i = 0; i < 14; i++) img.push_back({8'(i), 8'(8'h30 + i)});
        for (int i = 128; i < 139; i++) img.push_back({8'(i), 8'(8'h60 + i - 128)});
        img.push_back({8'd139, 8'hF0});
        k = 0;
        idx = 0;
        while (idx < img.size()) begin
            if (k % 3 == 2) begin
                bus.ld_valid = 1'b0;
                tick();
            end else begin
                bus.ld_valid = 1'b1;
                bus.ld_addr  = img[idx][15:8];
                bus.ld_data  = img[idx][7:0];
                bus.ld_last  = (idx == img.size() - 1);
                exp_q.push_back(img[idx]);
                tick();
                idx++;
            end
            k++;
            if (idx < img.size()) check("img_in_load", {29'b0, state}, 32'd2);
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("img_all_written", exp_q.size(), 32'd0);
        check_release_to_run();

        // halt on the 40th RUN cycle; start in RUN ignored
        repeat (9) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ignored", {29'b0, state}, 32'd4);
        check("run_count_10", {16'b0, cycle_count}, 32'd10);
        repeat (29) tick();
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        check("halt_state", {29'b0, state}, 32'd5);
        check("halt_done", {31'b0, done}, 32'd1);
        check("halt_count", {16'b0, cycle_count}, 32'd40);
        check("halt_core_rst_n", {31'b0, core_rst_n}, 32'd1);
        check("halt_busy", {31'b0, busy}, 32'd0);
        tick();
        check("halt_done_pulse", {31'b0, done}, 32'd0);
        check("halt_hold_count", {16'b0, cycle_count}, 32'd40);
        check("halt_hold_rst_n", {31'b0, core_rst_n}, 32'd1);

        // timeout at run_limit=100
        run_limit = 16'd100;
        do_clear();
        load_word(8'h00, 8'hF0, 1'b1);
        check_release_to_run();
        repeat (99) tick();
        check("to_pre_state", {29'b0, state}, 32'd4);
        check("to_pre_count", {16'b0, cycle_count}, 32'd99);
        tick();
        check("to_state", {29'b0, state}, 32'd6);
        check("to_timeout", {31'b0, timeout}, 32'd1);
        check("to_done", {31'b0, done}, 32'd1);
        check("to_core_rst_n", {31'b0, core_rst_n}, 32'd0);
        check("to_mem_sel", {31'b0, bus.mem_sel}, 32'd1);
        check("to_count", {16'b0, cycle_count}, 32'd100);
        tick();
        check("to_done_pulse", {31'b0, done}, 32'd0);
        check("to_sticky", {31'b0, timeout}, 32'd1);

        // restart from TIMEOUT; halt coinciding with the limit wins
        do_clear();
        load_word(8'h00, 8'hF0, 1'b1);
        check_release_to_run();
        repeat (99) tick();
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        check("hl_state", {29'b0, state}, 32'd5);
        check("hl_timeout", {31'b0, timeout}, 32'd0);
        check("hl_count", {16'b0, cycle_count}, 32'd100);
        check("hl_done", {31'b0, done}, 32'd1);
        tick();
        check("end_no_stray_writes", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
